// File: rtl/datapath_sequencer_if.sv
// Command handshake and RA/RB/RZ enable bundle for datapath_sequencer.
// SEQ_STEP_EN adds the single-step qualifier 'step'.
interface datapath_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
`ifdef SEQ_STEP_EN
    logic             step;
`endif
    logic             busy;
    logic             done;
    logic             RAin;
    logic             RBin;
    logic             RZin;
    logic             RAout;
    logic             RBout;
    logic             RZout;

    modport master (
        output start, op, count,
`ifdef SEQ_STEP_EN
        output step,
`endif
        input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout
    );

    modport slave (
        input  start, op, count,
`ifdef SEQ_STEP_EN
        input  step,
`endif
        output busy, done, RAin, RBin, RZin, RAout, RBout, RZout
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Microcode-style sequencer for the 8-bit RA/RB/RZ single-bus datapath.
// Optional SEQ_STEP_EN: non-IDLE states advance only on step=1.
module datapath_sequencer #(
    parameter int CNT_W   = 4,
    parameter int ACC_MAX = 15
) (
    input logic                  clock,
    input logic                  clear,
    datapath_sequencer_if.slave  sif
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOADA, S_MOVE, S_ADD0, S_ADD1, S_ACC0, S_ACC1, S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] ACC_MAX_C = ACC_MAX[CNT_W-1:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_lat;
    logic             adv;
    logic             busy_q, done_q;
    logic             rain_q, rbin_q, rzin_q, raout_q, rbout_q, rzout_q;

    assign cnt_lat = (sif.count > ACC_MAX_C) ? ACC_MAX_C : sif.count;
`ifdef SEQ_STEP_EN
    assign adv = sif.step;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (sif.start) begin
                    unique case (sif.op)
                        2'b00: state_d = S_LOADA;
                        2'b01: state_d = S_MOVE;
                        2'b10: state_d = S_ADD0;
                        default: begin
                            cnt_d   = cnt_lat;
                            state_d = (cnt_lat == '0) ? S_DONE : S_ACC0;
                        end
                    endcase
                end
            end
            S_LOADA: if (adv) state_d = S_DONE;
            S_MOVE:  if (adv) state_d = S_DONE;
            S_ADD0:  if (adv) state_d = S_ADD1;
            S_ADD1:  if (adv) state_d = S_DONE;
            S_ACC0:  if (adv) state_d = S_ACC1;
            S_ACC1: begin
                if (adv) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_ACC0;
                end
            end
            S_DONE:  if (adv) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered value tracks the state it belongs to.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rain_q  <= 1'b0;
            rbin_q  <= 1'b0;
            rzin_q  <= 1'b0;
            raout_q <= 1'b0;
            rbout_q <= 1'b0;
            rzout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            rain_q  <= (state_d == S_LOADA);
            rbin_q  <= (state_d == S_MOVE) || (state_d == S_ADD1) || (state_d == S_ACC1);
            rzin_q  <= (state_d == S_ADD0) || (state_d == S_ACC0);
            raout_q <= (state_d == S_MOVE) || (state_d == S_ADD0);
            rbout_q <= (state_d == S_ACC0);
            rzout_q <= (state_d == S_ADD1) || (state_d == S_ACC1);
        end
    end

    assign sif.busy  = busy_q;
    assign sif.done  = done_q;
    assign sif.RAin  = rain_q;
    assign sif.RBin  = rbin_q;
    assign sif.RZin  = rzin_q;
    assign sif.RAout = raout_q;
    assign sif.RBout = rbout_q;
    assign sif.RZout = rzout_q;
endmodule
